muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 26 ++
 rtl/muldiv_ctrl.sv | 166 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: operation encodings, FSM state encoding and small op-decode helpers.
package muldiv_ctrl_pkg;

    localparam logic [1:0] MDOP_MULT  = 2'd0;
    localparam logic [1:0] MDOP_MULTU = 2'd1;
    localparam logic [1:0] MDOP_DIV   = 2'd2;
    localparam logic [1:0] MDOP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    function automatic logic op_is_signed(input logic [1:0] o);
        return (o == MDOP_MULT) || (o == MDOP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] o);
        return (o == MDOP_DIV) || (o == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Latency: done pulses in the cycle after edge start+N+1 (sampled by edge start+N+2); busy for N+1 cycles.
// Backpressure: none; start is ignored while busy, abort cancels an in-flight op without done.
// Ports: clk, reset (async active-low), start/op/s/t request, abort, hi_we/lo_we/wdata direct
//        HI/LO writes, busy/done/div_by_zero status, hi/lo architectural results.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] s,
    input  logic [N-1:0] t,
    input  logic         abort,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N) + 1;

    md_state_t      r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_op;
    logic [N-1:0]   r_a;        // product high half / partial remainder
    logic [N-1:0]   r_b;        // product low half (multiplier) / quotient (dividend)
    logic [N-1:0]   r_m;        // multiplicand / divisor magnitude
    logic           r_neg_q;    // negate product or quotient
    logic           r_neg_r;    // negate remainder (dividend was negative)
    logic           r_dz;
    logic           r_done, r_dbz;
    logic [N-1:0]   r_hi, r_lo;

    logic           w_load, w_iter, w_commit;
    logic           w_signed;
    logic [N-1:0]   w_s_mag, w_t_mag;
    logic [N:0]     w_sum;
    logic [N:0]     w_shift;
    logic           w_ge;
    logic [2*N-1:0] w_prod, w_prod_fix;
    logic [N-1:0]   w_quo, w_rem, w_res_hi, w_res_lo;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_iter      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // abort in IDLE suppresses a simultaneous start
                if (start && !abort) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_iter = 1'b1;
                    if (r_cnt == CW'(N - 1)) w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_IDLE;
                if (!abort) w_commit = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- operand conditioning ----------------
    assign w_signed = op_is_signed(op);
    assign w_s_mag  = (w_signed && s[N-1]) ? -s : s;
    assign w_t_mag  = (w_signed && t[N-1]) ? -t : t;

    // ---------------- iteration datapath ----------------
    // Multiply: add multiplicand into the high half when the multiplier LSB is set, then
    // shift the {carry, hi, lo} triple right by one.
    assign w_sum   = {1'b0, r_a} + (r_b[0] ? {1'b0, r_m} : {(N+1){1'b0}});
    // Restoring divide: shift the next dividend bit into the remainder and subtract if it fits.
    // A fitting difference is below the divisor, so the low N bits hold it exactly.
    assign w_shift = {r_a, r_b[N-1]};
    assign w_ge    = (w_shift >= {1'b0, r_m});

    // ---------------- sign fix-up ----------------
    assign w_prod     = {r_a, r_b};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_b : r_b;
    assign w_rem      = r_neg_r ? -r_a : r_a;
    assign w_res_hi   = op_is_div(r_op) ? w_rem : w_prod_fix[2*N-1:N];
    assign w_res_lo   = op_is_div(r_op) ? w_quo : w_prod_fix[N-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_op    <= MDOP_MULT;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= w_commit;
            r_dbz  <= w_commit && r_dz;

            if (w_load) begin
                r_op    <= op;
                r_cnt   <= '0;
                r_a     <= '0;
                r_b     <= w_s_mag;
                r_m     <= w_t_mag;
                r_neg_q <= w_signed && (s[N-1] ^ t[N-1]);
                r_neg_r <= w_signed && s[N-1];
                r_dz    <= op_is_div(op) && (t == '0);
            end else if (w_iter) begin
                r_cnt <= r_cnt + CW'(1);
                if (op_is_div(r_op)) begin
                    r_a <= w_ge ? (w_shift[N-1:0] - r_m) : w_shift[N-1:0];
                    r_b <= {r_b[N-2:0], w_ge};
                end else begin
                    r_a <= w_sum[N:1];
                    r_b <= {w_sum[0], r_b[N-1:1]};
                end
            end

            // Direct writes land only while idle (including the start-accept cycle);
            // a divide by zero leaves HI/LO untouched.
            if (w_commit) begin
                if (!(op_is_div(r_op) && r_dz)) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end else if (r_state == ST_IDLE) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed operations push expected HI/LO/flag/done-cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [N-1:0] s = '0;
    logic [N-1:0] t = '0;
    logic         abort = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [N-1:0] wdata = '0;
    logic         busy, done, div_by_zero;
    logic [N-1:0] hi, lo;

    muldiv_ctrl #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .s(s), .t(t),
        .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        string        name;
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (div_by_zero && !done) chk("dbz_without_done", 32'(done), 32'd1);
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                    chk({e.name, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
                    chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Called at a negedge; the following posedge is the start edge, so done is
    // high in the cycle after edge (start+N+1), i.e. cyc = now + N + 2 here.
    task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit push, input string nm,
                         input logic [N-1:0] eh, input logic [N-1:0] el, input logic ed);
        exp_t e;
        op = o; s = a; t = b; start = 1'b1;
        if (push) begin
            e.name = nm; e.hi = eh; e.lo = el; e.dbz = ed; e.cyc = cyc + N + 2;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < N + 10 && !done; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(MDOP_MULT, 32'hFFFFFFFF, 32'd2, 1'b1, "mult_m1x2", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        wait_done(bc);
        chk("busy_cycles", 32'(bc), 32'(N + 1));
        @(negedge clk);

        issue(MDOP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, "multu_big_x2", 32'h00000001, 32'hFFFFFFFE, 1'b0);
        wait_done(bc);
        @(negedge clk);

        issue(MDOP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, "div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        wait_done(bc);
        @(negedge clk);

        issue(MDOP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf", 32'h0, 32'h80000000, 1'b0);
        wait_done(bc);
        @(negedge clk);

        // mthi / mtlo
        hi_we = 1'b1; wdata = 32'h11;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mthi", hi, 32'h11);
        chk("mtlo", lo, 32'h22);

        issue(MDOP_DIVU, 32'd7, 32'd0, 1'b1, "divu_by_zero", 32'h11, 32'h22, 1'b1);
        wait_done(bc);
        @(negedge clk);

        // Abort in the 10th RUN cycle; a start and an mthi while busy are both dropped.
        issue(MDOP_MULTU, 32'd3, 32'd5, 1'b0, "", '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; op = MDOP_DIVU; hi_we = 1'b1; wdata = 32'h99;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'h11);
        chk("abort_lo", lo, 32'h22);
        repeat (N + 5) @(negedge clk);

        // abort wins over start in IDLE
        start = 1'b1; abort = 1'b1; op = MDOP_MULTU;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", 32'(busy), 32'd0);
        repeat (N + 5) @(negedge clk);

        // mthi in the accept cycle lands, then the result overwrites it; back-to-back start.
        hi_we = 1'b1; wdata = 32'hDEAD;
        issue(MDOP_MULTU, 32'd6, 32'd7, 1'b1, "multu_6x7", 32'h0, 32'd42, 1'b0);
        hi_we = 1'b0;
        chk("write_in_accept", hi, 32'hDEAD);
        wait_done(bc);
        issue(MDOP_DIVU, 32'd100, 32'd7, 1'b1, "divu_100_7", 32'd2, 32'd14, 1'b0);
        wait_done(bc);
        @(negedge clk);

        // reset mid-RUN
        issue(MDOP_MULTU, 32'd3, 32'd5, 1'b0, "", '0, '0, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrun_reset_hi", hi, 32'h0);
        chk("midrun_reset_lo", lo, 32'h0);
        chk("midrun_reset_busy", 32'(busy), 32'd0);
        chk("midrun_reset_done", 32'(done), 32'd0);
        chk("midrun_reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (N + 5) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
